booth_mul_sched: RTL and testbench

//  Round-robin scheduler that shares one pipelined radix-4 Booth multiplier (Dadda-tree core) among NREQ requesters.

---
 rtl/booth_mul_sched_pkg.sv | 22 ++
 rtl/booth_mul_sched_if.sv | 25 ++
 rtl/booth_mul_sched_rr_arbiter.sv | 29 ++
 rtl/booth_mul_sched.sv | 103 ++++++++++
 tb/tb_booth_mul_sched.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_mul_sched_pkg.sv
// Shared types for the Booth multiplier scheduler: requester state, in-flight tag, index width.
package booth_mul_sched_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned IDX_W    = idx_w(NREQ_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } req_state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/booth_mul_sched_if.sv
// Requester-side operand and result handshakes of the shared multiplier scheduler.
interface booth_mul_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned A_W  = 10,
  parameter int unsigned P_W  = 20
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*A_W-1:0] req_b;
  logic [NREQ-1:0]     res_valid;
  logic [NREQ-1:0]     res_ready;
  logic [P_W-1:0]      res_p;
  logic [NREQ*P_W-1:0] res_p_all;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_p, res_p_all
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_p_all
  );
endinterface

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the pointer (wrapping) wins.
import booth_mul_sched_pkg::*;

module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);
  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found        = 1'b1;
        o_gnt[w_cand]  = 1'b1;
        o_gnt_idx      = w_cand;
      end
    end
  end
endmodule

// File: rtl/booth_mul_sched.sv
// Shares one fixed-latency multiplier among NREQ requesters: RR issue, tag tracking, per-requester result hold.
import booth_mul_sched_pkg::*;

module booth_mul_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned A_W     = 10,
  parameter int unsigned P_W     = 20,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  booth_mul_sched_if.slave    bus,
  output logic                o_mul_in_valid,
  output logic [A_W-1:0]      o_mul_a,
  output logic [A_W-1:0]      o_mul_b,
  input  logic [P_W-1:0]      i_mul_p,
  output logic                o_busy
);
  req_state_t       r_state    [NREQ];
  logic [P_W-1:0]   r_hold     [NREQ];
  logic [IDX_W-1:0] r_ptr;
  tag_t             r_tag_in;
  tag_t             r_tag_pipe [MUL_LAT];

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_any_gnt;
  logic [A_W-1:0]   w_sel_a;
  logic [A_W-1:0]   w_sel_b;
  logic [IDX_W-1:0] w_ptr_nxt;
  tag_t             w_ret;

  // Grants are suppressed while reset is held so no handshake can be lost.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_elig[i] = bus.req_valid[i] && (r_state[i] == IDLE) && !rst;
    end
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign bus.req_ready = w_gnt;
  assign w_any_gnt     = |w_gnt;
  assign w_sel_a       = bus.req_a[32'(w_gnt_idx)*A_W +: A_W];
  assign w_sel_b       = bus.req_b[32'(w_gnt_idx)*A_W +: A_W];
  assign w_ptr_nxt     = IDX_W'((32'(w_gnt_idx) + 1) % NREQ);
  assign w_ret         = r_tag_pipe[MUL_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr          <= '0;
      r_tag_in       <= '0;
      o_mul_in_valid <= 1'b0;
      o_mul_a        <= '0;
      o_mul_b        <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) r_tag_pipe[k] <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_state[i] <= IDLE;
        r_hold[i]  <= '0;
      end
    end else begin
      o_mul_in_valid <= w_any_gnt;
      r_tag_in       <= '{vld: w_any_gnt, idx: w_gnt_idx};
      r_tag_pipe[0]  <= r_tag_in;
      for (int unsigned k = 1; k < MUL_LAT; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
      if (w_any_gnt) begin
        o_mul_a <= w_sel_a;
        o_mul_b <= w_sel_b;
        r_ptr   <= w_ptr_nxt;
      end
      // Grant, return and result handshake each touch a requester in a different state.
      for (int unsigned i = 0; i < NREQ; i++) begin
        case (r_state[i])
          IDLE:     if (w_gnt[i]) r_state[i] <= INFLIGHT;
          INFLIGHT: if (w_ret.vld && (w_ret.idx == IDX_W'(i))) begin
                      r_state[i] <= DONE;
                      r_hold[i]  <= i_mul_p;
                    end
          DONE:     if (bus.res_ready[i]) r_state[i] <= IDLE;
          default:  r_state[i] <= IDLE;
        endcase
      end
    end
  end

  // Lowest-index valid slot drives the shared result bus.
  always_comb begin
    bus.res_p = '0;
    o_busy    = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      bus.res_valid[i]              = (r_state[i] == DONE);
      bus.res_p_all[i*P_W +: P_W]   = r_hold[i];
      if (r_state[i] == DONE) bus.res_p = r_hold[i];
      if (r_state[i] != IDLE) o_busy = 1'b1;
    end
  end
endmodule

// File: tb/tb_booth_mul_sched.sv
// Bench for booth_mul_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_booth_mul_sched;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned A_W     = 10;
  localparam int unsigned P_W     = 20;
  localparam int unsigned MUL_LAT = 2;

  logic           clk;
  logic           rst;
  logic           miv;
  logic [A_W-1:0] ma, mb;
  logic [P_W-1:0] mp;
  logic           busy;

  booth_mul_sched_if #(.NREQ(NREQ), .A_W(A_W), .P_W(P_W)) bus ();

  booth_mul_sched #(.NREQ(NREQ), .A_W(A_W), .P_W(P_W), .MUL_LAT(MUL_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .o_mul_in_valid (miv),
    .o_mul_a        (ma),
    .o_mul_b        (mb),
    .i_mul_p        (mp),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: product appears MUL_LAT cycles after its operands.
  logic [P_W-1:0] p_pipe [MUL_LAT];
  always @(posedge clk) begin
    p_pipe[0] <= P_W'(ma) * P_W'(mb);
    for (int k = 1; k < MUL_LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mp = p_pipe[MUL_LAT-1];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s cyc=%0d timed out", nm, cyc);
  endtask

  // Transaction-level model: owed product, due cycle, held result, RR pointer.
  bit             pend  [NREQ];
  bit             mrv   [NREQ];
  int unsigned    due   [NREQ];
  logic [P_W-1:0] mprod [NREQ];
  logic [P_W-1:0] mhold [NREQ];
  int             mptr;
  logic           emiv;
  logic [A_W-1:0] ema, emb;
  bit             armed = 0;

  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; mrv[i] = 0; due[i] = 0; mprod[i] = '0; mhold[i] = '0;
    end
    mptr = 0; emiv = 1'b0; ema = '0; emb = '0;
  endtask

  always @(negedge clk) begin
    logic [NREQ-1:0]     er, erv;
    logic [NREQ*P_W-1:0] eall;
    logic [P_W-1:0]      ep;
    int                  g;
    if (armed) begin
      for (int i = 0; i < NREQ; i++)
        if (pend[i] && !mrv[i] && due[i] == cyc) begin mhold[i] = mprod[i]; mrv[i] = 1; end
      er = '0; g = -1;
      if (!rst)
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (mptr + k) % NREQ;
          if (g < 0 && bus.req_valid[idx] && !pend[idx]) g = idx;
        end
      if (g >= 0) er[g] = 1'b1;
      ep = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
        erv[i] = mrv[i];
        eall[i*P_W +: P_W] = mhold[i];
        if (mrv[i]) ep = mhold[i];
      end
      chk("req_ready", bus.req_ready, er);
      chk("res_valid", bus.res_valid, erv);
      chk("res_p_all", bus.res_p_all, eall);
      if (|erv) chk("res_p", bus.res_p, ep);
      chk("busy", busy, (|erv) || pend.or() != 0);
      chk("mul_in_valid", miv, emiv);
      chk("mul_a", ma, ema);
      chk("mul_b", mb, emb);
      if (rst) model_clear();
      else begin
        if (g >= 0) begin
          pend[g]  = 1;
          due[g]   = cyc + MUL_LAT + 2;
          mprod[g] = P_W'(bus.req_a[g*A_W +: A_W]) * P_W'(bus.req_b[g*A_W +: A_W]);
          mptr     = (g + 1) % NREQ;
          emiv     = 1'b1;
          ema      = bus.req_a[g*A_W +: A_W];
          emb      = bus.req_b[g*A_W +: A_W];
        end else emiv = 1'b0;
        for (int i = 0; i < NREQ; i++)
          if (mrv[i] && bus.res_ready[i]) begin mrv[i] = 0; pend[i] = 0; end
      end
    end else if (rst) begin
      armed = 1;
      model_clear();
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [A_W-1:0] a, input logic [A_W-1:0] b);
    bus.req_a[i*A_W +: A_W] = a;
    bus.req_b[i*A_W +: A_W] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_ops(i, A_W'($urandom), A_W'($urandom));
  endtask

  task automatic do_single(input int idx, input logic [A_W-1:0] a, input logic [A_W-1:0] b,
                           input logic [P_W-1:0] exp, input string nm);
    int n;
    step();
    bus.req_valid = '0;
    bus.req_valid[idx] = 1'b1;
    set_ops(idx, a, b);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[idx] && n < 20) begin step(); @(negedge clk); n++; end
    if (n >= 20) timeout({nm, "_grant"});
    step();
    bus.req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!bus.res_valid[idx] && n < 20) begin step(); @(negedge clk); n++; end
    if (n >= 20) timeout({nm, "_result"});
    else chk(nm, bus.res_p_all[idx*P_W +: P_W], exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] seq [6];
    logic [P_W-1:0]  exp1;
    bit              got;
    int              n;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
    rst = 1'b1;
    bus.req_valid = '0; bus.res_ready = '0; bus.req_a = '0; bus.req_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // All four requesting every cycle from pointer 0.
    step();
    bus.req_valid = '1; bus.res_ready = '1; rand_ops();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_all_grant", bus.req_ready, seq[c]);
      step();
      rand_ops();
    end
    bus.req_valid = '0;
    repeat (10) step();

    // Single op on requester 2 with exact latency.
    bus.req_valid = 4'b0100; bus.res_ready = '0; set_ops(2, 10'd25, 10'd40);
    @(negedge clk); chk("single_ready", bus.req_ready, 4'b0100);
    step(); bus.req_valid = '0;
    @(negedge clk); chk("single_miv", miv, 1'b1);
    chk("single_mul_a", ma, 10'd25); chk("single_mul_b", mb, 10'd40);
    step(); step();
    @(negedge clk); chk("single_early", bus.res_valid, 4'b0000);
    step();
    @(negedge clk); chk("single_rv", bus.res_valid, 4'b0100);
    chk("single_p", bus.res_p, 20'd1000);
    step(); bus.res_ready = '1;
    step();

    // Pointer at 3 wraps to 0.
    bus.req_valid = 4'b1001; set_ops(0, 10'd3, 10'd5); set_ops(3, 10'd11, 10'd13);
    @(negedge clk); chk("wrap_first", bus.req_ready, 4'b1000);
    step(); @(negedge clk); chk("wrap_second", bus.req_ready, 4'b0001);
    step(); @(negedge clk); chk("wrap_none", bus.req_ready, 4'b0000);
    step(); bus.req_valid = '0;
    repeat (8) step();

    do_single(1, 10'd1023, 10'd1023, 20'd1046529, "ext_max");
    do_single(3, 10'd0, 10'd777, 20'd0, "ext_zero");
    repeat (4) step();

    // Reset one cycle after a grant to requester 0 discards that op.
    bus.req_valid = 4'b0001; set_ops(0, 10'd100, 10'd200);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[0] && n < 20) begin step(); @(negedge clk); n++; end
    if (n >= 20) timeout("rst_grant");
    step(); rst = 1'b1; bus.req_valid = '0;
    step(); rst = 1'b0;
    bus.req_valid = 4'b1001; set_ops(0, 10'd7, 10'd9); set_ops(3, 10'd1, 10'd1);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rv", bus.res_valid, 4'b0000);
    chk("rst_ptr", bus.req_ready, 4'b0001);
    step(); bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("rst_no_stale", bus.res_valid, 4'b0000);
      step();
    end
    @(negedge clk); chk("rst_new_rv", bus.res_valid, 4'b0001);
    chk("rst_new_p", bus.res_p, 20'd63);
    repeat (4) step();

    // Back-pressure on requester 1 while others keep flowing.
    bus.res_ready = 4'b1101; bus.req_valid = '1; rand_ops();
    got = 0; n = 0; exp1 = '0;
    while (!got && n < 30) begin
      @(negedge clk);
      if (bus.req_ready[1])
        exp1 = P_W'(bus.req_a[1*A_W +: A_W]) * P_W'(bus.req_b[1*A_W +: A_W]);
      if (bus.res_valid[1]) got = 1;
      else begin step(); rand_ops(); n++; end
    end
    if (!got) timeout("bp_result");
    for (int c = 0; c < 10; c++) begin
      chk("bp_rv", bus.res_valid[1], 1'b1);
      chk("bp_hold", bus.res_p_all[1*P_W +: P_W], exp1);
      chk("bp_ready", bus.req_ready[1], 1'b0);
      step(); rand_ops();
      @(negedge clk);
    end
    step(); bus.res_ready = '1; bus.req_valid = '0;
    repeat (10) step();

    // Random traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      bus.req_valid = NREQ'($urandom);
      bus.res_ready = NREQ'($urandom);
      rand_ops();
    end
    step(); rst = 1'b0; bus.req_valid = '0; bus.res_ready = '1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
